// File: rtl/alu_iter.sv
// Iterative RV32/RV64 integer execute unit: single-cycle base ops, radix-2 MUL/DIV.
// Optional ALU_ITER_EARLY_OUT_EN lets trivial M ops (div-by-zero, overflow, zero factor) skip iteration.
module alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            ce_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic [2:0]      op_i,
  input  logic            op_qual_i,
  input  logic            op_ext_i,
  output logic [XLEN-1:0] out_o,
  output logic            busy_o,
  output logic            done_o
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [XLEN-1:0]     out_reg;
  logic                done_reg;
  logic [2*XLEN-1:0]   prod_reg;
  logic [XLEN-1:0]     opa_reg;
  logic [XLEN-1:0]     opb_reg;
  logic [XLEN-1:0]     quo_reg;
  logic [XLEN-1:0]     rem_reg;
  logic [2:0]          op_reg;
  logic                sgn1_reg;
  logic                sgn2_reg;
  logic                dz_reg;

  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0]        base_res;
  logic                   s1, s2;
  logic [XLEN-1:0]        mag1, mag2;
  logic [XLEN:0]          madd;
  logic [XLEN:0]          div_shift;
  logic [XLEN:0]          div_trial;
  logic [2*XLEN-1:0]      prod_fix;
  logic [XLEN-1:0]        quo_fix;
  logic [XLEN-1:0]        rem_fix;
  logic [XLEN-1:0]        fix_res;

  always_comb begin
    shamt   = in2_i[SHW-1:0];
    sra_res = $signed(in1_i) >>> shamt;
    base_res = '0;
    case (op_i)
      3'b000: base_res = op_qual_i ? (in1_i - in2_i) : (in1_i + in2_i);
      3'b010: base_res = {{(XLEN-1){1'b0}}, $signed(in1_i) < $signed(in2_i)};
      3'b011: base_res = {{(XLEN-1){1'b0}}, in1_i < in2_i};
      3'b100: base_res = in1_i ^ in2_i;
      3'b110: base_res = in1_i | in2_i;
      3'b111: base_res = in1_i & in2_i;
      3'b001: base_res = in1_i << shamt;
      3'b101: begin
        if (op_qual_i) base_res = sra_res;
        else           base_res = in1_i >> shamt;
      end
      default: base_res = '0;
    endcase

    // Operand signedness: DIV/REM both signed, MULH both, MULHSU only in1.
    s1 = in1_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10));
    s2 = in2_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01));
    mag1 = s1 ? -in1_i : in1_i;
    mag2 = s2 ? -in2_i : in2_i;

    madd      = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, opa_reg} : '0);
    div_shift = {rem_reg, quo_reg[XLEN-1]};
    div_trial = div_shift - {1'b0, opb_reg};

    // A zero divisor must leave the all-ones quotient untouched regardless of signs.
    prod_fix = (sgn1_reg ^ sgn2_reg) ? -prod_reg : prod_reg;
    quo_fix  = ((sgn1_reg ^ sgn2_reg) && !dz_reg) ? -quo_reg : quo_reg;
    rem_fix  = sgn1_reg ? -rem_reg : rem_reg;
    if (op_reg[2])                fix_res = op_reg[1] ? rem_fix : quo_fix;
    else if (op_reg[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
    else                          fix_res = prod_fix[2*XLEN-1:XLEN];
  end

`ifdef ALU_ITER_EARLY_OUT_EN
  logic early_out;
  always_comb begin
    if (op_i[2])
      early_out = (in2_i == '0) ||
                  (~op_i[0] && in1_i == {1'b1, {(XLEN-1){1'b0}}} && in2_i == '1);
    else
      early_out = (in1_i == '0) || (in2_i == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
      prod_reg  <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      op_reg    <= '0;
      sgn1_reg  <= 1'b0;
      sgn2_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else if (ce_i) begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (!op_ext_i) begin
              out_reg  <= base_res;
              done_reg <= 1'b1;
            end else begin
              op_reg    <= op_i;
              sgn1_reg  <= s1;
              sgn2_reg  <= s2;
              dz_reg    <= (in2_i == '0);
              opa_reg   <= mag1;
              opb_reg   <= mag2;
              prod_reg  <= {{XLEN{1'b0}}, mag2};
              quo_reg   <= mag1;
              rem_reg   <= '0;
              cnt_reg   <= CW'(XLEN);
              state_reg <= op_i[2] ? DIV : MUL;
`ifdef ALU_ITER_EARLY_OUT_EN
              // Preload the final magnitudes so FIX produces the corner result directly.
              if (early_out) begin
                state_reg <= FIX;
                cnt_reg   <= '0;
                prod_reg  <= '0;
                if (in2_i == '0) begin
                  quo_reg <= '1;
                  rem_reg <= mag1;
                end
              end
`endif
            end
          end
        end
        MUL: begin
          prod_reg <= {madd, prod_reg[XLEN-1:1]};
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) state_reg <= FIX;
        end
        DIV: begin
          if (!div_trial[XLEN]) begin
            rem_reg <= div_trial[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
          end else begin
            rem_reg <= div_shift[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) state_reg <= FIX;
        end
        FIX: begin
          out_reg   <= fix_res;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_o  = out_reg;
  assign busy_o = (state_reg != IDLE);
  assign done_o = done_reg;
endmodule

// File: tb/tb_alu_iter.sv
// Randomised and directed bench for alu_iter (XLEN=32) against a behavioural reference model.
module tb_alu_iter;
  localparam int XLEN = 32;
`ifdef ALU_ITER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_i, ce_i, start_i, op_qual_i, op_ext_i;
  logic [31:0] in1_i, in2_i;
  logic [2:0]  op_i;
  logic [31:0] out_o;
  logic        busy_o, done_o;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_i(reset_i), .ce_i(ce_i), .start_i(start_i),
    .in1_i(in1_i), .in2_i(in2_i), .op_i(op_i), .op_qual_i(op_qual_i),
    .op_ext_i(op_ext_i), .out_o(out_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_base(input logic [2:0] op, input logic q,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa;
    sa = longint'($signed(a));
    case (op)
      3'b000: return q ? a - b : a + b;
      3'b010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'b011: return (a < b) ? 32'd1 : 32'd0;
      3'b100: return a ^ b;
      3'b110: return a | b;
      3'b111: return a & b;
      3'b001: return a << b[4:0];
      default: begin
        if (q) return 32'(sa >>> b[4:0]);
        return a >> b[4:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    longint unsigned ua_u, ub_u;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b)); ub = longint'({32'd0, b});
    ua_u = {32'd0, a}; ub_u = {32'd0, b};
    ia = a; ib = b;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua_u * ub_u; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!EARLY) return 1'b0;
    if (op[2]) return (b == 0) || (!op[0] && a == MINV && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  // Spec-level model: result, remaining busy cycles, done pulse.
  logic [31:0] m_out, m_pend;
  int          m_left;
  logic        m_done;
  always @(posedge clk) begin
    if (reset_i) begin
      m_out <= '0; m_done <= 1'b0; m_left <= 0;
    end else if (ce_i) begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin m_out <= m_pend; m_done <= 1'b1; end
      end else if (start_i) begin
        if (!op_ext_i) begin
          m_out <= ref_base(op_i, op_qual_i, in1_i, in2_i);
          m_done <= 1'b1;
        end else begin
          m_pend <= ref_m(op_i, in1_i, in2_i);
          m_left <= is_early(op_i, in1_i, in2_i) ? 1 : XLEN + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", {32'd0, out_o}, {32'd0, m_out});
      check("busy", {63'd0, busy_o}, {63'd0, (m_left > 0)});
      check("done", {63'd0, done_o}, {63'd0, m_done});
    end
  end

  task automatic run_op(input string nm, input logic ext, input logic [2:0] op, input logic q,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int exp_k, input int stall_at, input int stall_len);
    int k;
    @(posedge clk); #1;
    op_ext_i = ext; op_i = op; op_qual_i = q; in1_i = a; in2_i = b; start_i = 1'b1; ce_i = 1'b1;
    k = -1;
    do begin
      @(posedge clk); #1;
      k++;
      start_i = 1'b0; in1_i = $urandom; in2_i = $urandom;
      if (k == stall_at) begin
        ce_i = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1; ce_i = 1'b1;
        k += stall_len;
      end
    end while (!done_o && k < 200);
    if (k >= 200) check({nm, "_timeout"}, 64'd1, 64'd0);
    check(nm, {32'd0, out_o}, {32'd0, exp});
    check({nm, "_lat"}, 64'(k), 64'(exp_k));
    $display("op %s: a=%h b=%h out=%h done_edge=%0d", nm, a, b, out_o, k);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk;
    int cnt;
    dk = EARLY ? 1 : 33;
    reset_i = 1'b1; ce_i = 1'b1; start_i = 1'b0; op_qual_i = 1'b0; op_ext_i = 1'b0;
    in1_i = '0; in2_i = '0; op_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {32'd0, out_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    reset_i = 1'b0; chk_en = 1'b1;

    run_op("sub", 0, 3'b000, 1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, -1, 0);
    run_op("sra", 0, 3'b101, 1, MINV, 32'h24, 32'hF800_0000, 0, -1, 0);
    run_op("srl", 0, 3'b101, 0, MINV, 32'h24, 32'h0800_0000, 0, -1, 0);
    run_op("mulh", 1, 3'b001, 0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, -1, 0);
    run_op("mul", 1, 3'b000, 0, 32'd7, 32'd6, 32'd42, 33, -1, 0);
    run_op("div_ovf", 1, 3'b100, 0, MINV, 32'hFFFF_FFFF, MINV, dk, -1, 0);
    run_op("rem_ovf", 1, 3'b110, 0, MINV, 32'hFFFF_FFFF, 32'd0, dk, -1, 0);
    run_op("remu_z", 1, 3'b111, 0, 32'd13, 32'd0, 32'd13, dk, -1, 0);
    run_op("divu_z", 1, 3'b101, 0, 32'd13, 32'd0, 32'hFFFF_FFFF, dk, -1, 0);
    run_op("div_stall", 1, 3'b100, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 43, 5, 10);
    run_op("rem_neg", 1, 3'b110, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, -1, 0);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    op_ext_i = 1'b1; op_i = 3'b000; in1_i = 32'd7; in2_i = 32'd6; start_i = 1'b1;
    repeat (13) begin @(posedge clk); #1; start_i = 1'b0; end
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_out", {32'd0, out_o}, 64'd0);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    run_op("add_after_rst", 0, 3'b000, 0, 32'd1, 32'd1, 32'd2, 0, -1, 0);

    // Random traffic: ops, ce gaps, starts while busy, occasional reset.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      ce_i      = ($urandom_range(0, 9) != 0);
      start_i   = ($urandom_range(0, 2) == 0);
      op_ext_i  = $urandom_range(0, 1);
      op_i      = 3'($urandom_range(0, 7));
      op_qual_i = $urandom_range(0, 1);
      in1_i     = pick();
      in2_i     = pick();
      reset_i   = ($urandom_range(0, 799) == 0);
      if (done_o && ce_i)
        $display("rnd %0d: done out=%h", i, out_o);
    end

    @(posedge clk); #1;
    reset_i = 1'b0; start_i = 1'b0; ce_i = 1'b1;
    cnt = 0;
    while (busy_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    if (cnt >= 100) check("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
    #1; chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
